// File: rtl/comp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding, default geometry and helpers that derive digit count and index
// widths from the operand and digit widths.
package comp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    // Number of DIGIT-bit slices in a WIDTH-bit operand.
    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of the digit index register; at least one bit even for NDIG=1.
    function automatic int calc_idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    // Width of the digit-count output, wide enough to hold NDIG itself.
    function automatic int calc_cyc_w(input int ndig);
        return $clog2(ndig) + 1;
    endfunction

    localparam int DEF_NDIG  = calc_ndig(DEF_WIDTH, DEF_DIGIT);
    localparam int DEF_IDX_W = calc_idx_w(DEF_NDIG);
    localparam int DEF_CYC_W = calc_cyc_w(DEF_NDIG);

endpackage

// File: rtl/digit_comp.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_comp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    // Three mutually exclusive relations of the two slices.
    always_comb begin
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
    end

endmodule

// File: rtl/seq_mag_comp.sv
// Sequential magnitude comparator: scans two captured operands one digit
// per cycle, MSB digit first, and stops at the first differing digit.
// Signed compares are turned into unsigned ones by flipping both MSBs at
// capture time.
module seq_mag_comp
    import comp_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DIGIT = DEF_DIGIT,
    localparam int NDIG  = calc_ndig(WIDTH, DIGIT),
    localparam int IDX_W = calc_idx_w(NDIG),
    localparam int CYC_W = calc_cyc_w(NDIG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             greater,
    output logic             equal,
    output logic [CYC_W-1:0] cycles
);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_less;
    logic               r_greater;
    logic               r_equal;
    logic [CYC_W-1:0]   r_cycles;

    logic [WIDTH-1:0]   w_msb_mask;
    logic [DIGIT-1:0]   w_slice_a;
    logic [DIGIT-1:0]   w_slice_b;
    logic               w_lt;
    logic               w_gt;
    logic               w_eq;
    logic               w_accept;
    logic               w_last_digit;
    logic [CYC_W-1:0]   w_cycles_k;

    // A new compare is taken in any state except while scanning.
    assign w_accept     = start && (r_state != S_SCAN);
    assign w_msb_mask   = {signed_mode, {(WIDTH-1){1'b0}}};
    assign w_last_digit = (r_idx == {IDX_W{1'b0}});
    // Digits examined so far, counting the current one.
    assign w_cycles_k   = CYC_W'(NDIG) - CYC_W'(r_idx);

    // AND-OR mux selecting the digit slice addressed by the scan index.
    always_comb begin
        w_slice_a = {DIGIT{1'b0}};
        w_slice_b = {DIGIT{1'b0}};
        for (int i = 0; i < NDIG; i++) begin
            w_slice_a = w_slice_a | (r_a[i*DIGIT +: DIGIT] & {DIGIT{r_idx == IDX_W'(i)}});
            w_slice_b = w_slice_b | (r_b[i*DIGIT +: DIGIT] & {DIGIT{r_idx == IDX_W'(i)}});
        end
    end

    digit_comp #(
        .DIGIT (DIGIT)
    ) u_digit_comp (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .lt (w_lt),
        .gt (w_gt),
        .eq (w_eq)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic: early exit on a differing digit or after the last digit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_SCAN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!w_eq || w_last_digit) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_SCAN;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_next_state = S_SCAN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, digit index walk, registered status and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_less    <= 1'b0;
            r_greater <= 1'b0;
            r_equal   <= 1'b0;
            r_cycles  <= {CYC_W{1'b0}};
        end else begin
            r_busy <= (w_next_state == S_SCAN);
            r_done <= (w_next_state == S_DONE);
            if (w_accept) begin
                r_a   <= a ^ w_msb_mask;
                r_b   <= b ^ w_msb_mask;
                r_idx <= IDX_W'(NDIG - 1);
            end else if (r_state == S_SCAN) begin
                if (!w_eq) begin
                    r_less    <= w_lt;
                    r_greater <= w_gt;
                    r_equal   <= 1'b0;
                    r_cycles  <= w_cycles_k;
                end else if (w_last_digit) begin
                    r_less    <= 1'b0;
                    r_greater <= 1'b0;
                    r_equal   <= 1'b1;
                    r_cycles  <= CYC_W'(NDIG);
                end else begin
                    r_idx <= r_idx - IDX_W'(1);
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign less    = r_less;
    assign greater = r_greater;
    assign equal   = r_equal;
    assign cycles  = r_cycles;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Self-checking bench for seq_mag_comp (WIDTH=16, DIGIT=4): directed cases,
// ignored/back-to-back starts, mid-scan reset and random operands, with a
// queue of expected results checked when done is seen.
module tb_seq_mag_comp;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = 4;

    typedef struct packed {
        logic       lt;
        logic       gt;
        logic       eq;
        logic [2:0] cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        less;
    logic        greater;
    logic        equal;
    logic [2:0]  cycles;

    res_t exp_q[$];
    res_t last_res;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_mag_comp #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .less        (less),
        .greater     (greater),
        .equal       (equal),
        .cycles      (cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic res_t mk(input logic lt, input logic gt, input logic eq, input int cyc);
        res_t r;
        r.lt  = lt;
        r.gt  = gt;
        r.eq  = eq;
        r.cyc = 3'(cyc);
        return r;
    endfunction

    // Reference: direct signed/unsigned relation plus leading-differing-digit count.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic sm);
        res_t r;
        int   k;
        logic found;
        if (sm) begin
            r.lt = ($signed(x) < $signed(y));
            r.gt = ($signed(x) > $signed(y));
        end else begin
            r.lt = (x < y);
            r.gt = (x > y);
        end
        r.eq  = (x == y);
        k     = 0;
        found = 1'b0;
        for (int d = NDIG - 1; d >= 0; d--) begin
            if (!found) begin
                k++;
                if (x[d*DIGIT +: DIGIT] != y[d*DIGIT +: DIGIT]) found = 1'b1;
            end
        end
        r.cyc = 3'(k);
        return r;
    endfunction

    // Called at a negedge: drive start for one edge, then scramble operands.
    task automatic start_cmp(input logic [15:0] x, input logic [15:0] y, input logic sm, input res_t e);
        a           = x;
        b           = y;
        signed_mode = sm;
        start       = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        signed_mode = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("done_after_accept", 32'(done), 32'd0);
        chk("hold_less",    32'(less),    32'(last_res.lt));
        chk("hold_greater", 32'(greater), 32'(last_res.gt));
        chk("hold_equal",   32'(equal),   32'(last_res.eq));
        chk("hold_cycles",  32'(cycles),  32'(last_res.cyc));
    endtask

    // Wait (bounded) for done; elapsed0 = edges already seen since the accept edge.
    task automatic wait_result(input int elapsed0);
        int   el;
        bit   got;
        res_t e;
        el  = elapsed0;
        got = 1'b0;
        while (!got && el < NDIG + 2) begin
            @(negedge clk);
            el++;
            if (done === 1'b1) got = 1'b1;
        end
        e = exp_q.pop_front();
        chk("done_seen",    32'(got),     32'd1);
        chk("latency",      32'(el),      32'(e.cyc));
        chk("less",         32'(less),    32'(e.lt));
        chk("greater",      32'(greater), 32'(e.gt));
        chk("equal",        32'(equal),   32'(e.eq));
        chk("cycles",       32'(cycles),  32'(e.cyc));
        chk("busy_in_done", 32'(busy),    32'd0);
        chk("onehot",       32'(less) + 32'(greater) + 32'(equal), 32'd1);
        last_res = e;
    endtask

    task automatic run(input logic [15:0] x, input logic [15:0] y, input logic sm, input res_t e);
        start_cmp(x, y, sm, e);
        wait_result(0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy",      32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] x;
        logic [15:0] y;
        logic        sm;
        int          d;

        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = 16'h0000;
        b           = 16'h0000;
        last_res    = '0;

        // Reset state, and reset wins over start.
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 16'h8000;
        b     = 16'h0001;
        @(negedge clk);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_less",    32'(less),    32'd0);
        chk("rst_greater", 32'(greater), 32'd0);
        chk("rst_equal",   32'(equal),   32'd0);
        chk("rst_cycles",  32'(cycles),  32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Directed cases.
        run(16'h1234, 16'h1234, 1'b0, mk(1'b0, 1'b0, 1'b1, 4));
        run(16'h8000, 16'h7FFF, 1'b0, mk(1'b0, 1'b1, 1'b0, 1));
        run(16'h8000, 16'h7FFF, 1'b1, mk(1'b1, 1'b0, 1'b0, 1));
        run(16'h0012, 16'h0013, 1'b0, mk(1'b1, 1'b0, 1'b0, 4));
        run(16'hFFFF, 16'hFFFE, 1'b1, mk(1'b0, 1'b1, 1'b0, 4));
        run(16'h0550, 16'h0540, 1'b0, mk(1'b0, 1'b1, 1'b0, 3));

        // Start during SCAN is ignored; a start in the DONE cycle is taken at once.
        start_cmp(16'h1234, 16'h1234, 1'b0, mk(1'b0, 1'b0, 1'b1, 4));
        start       = 1'b1;
        a           = 16'h0000;
        b           = 16'hFFFF;
        signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_busy", 32'(busy), 32'd1);
        chk("ignored_done", 32'(done), 32'd0);
        wait_result(1);
        start_cmp(16'hA5C3, 16'hA5C7, 1'b0, mk(1'b1, 1'b0, 1'b0, 4));
        wait_result(0);
        @(negedge clk);
        chk("b2b_done_one_cycle", 32'(done), 32'd0);

        // Reset in the second SCAN cycle abandons the compare.
        start_cmp(16'h1234, 16'h1234, 1'b0, mk(1'b0, 1'b0, 1'b1, 4));
        @(negedge clk);
        chk("scan2_busy", 32'(busy), 32'd1);
        chk("scan2_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_front());
        last_res = '0;
        chk("midrst_busy",    32'(busy),    32'd0);
        chk("midrst_done",    32'(done),    32'd0);
        chk("midrst_less",    32'(less),    32'd0);
        chk("midrst_greater", 32'(greater), 32'd0);
        chk("midrst_equal",   32'(equal),   32'd0);
        chk("midrst_cycles",  32'(cycles),  32'd0);
        repeat (NDIG + 1) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(done), 32'd0);
        end
        run(16'h4000, 16'h3FFF, 1'b1, mk(1'b0, 1'b1, 1'b0, 1));

        // Random operands, biased so every leading-difference position occurs.
        for (int i = 0; i < 1000; i++) begin
            x  = 16'($urandom);
            y  = x;
            sm = 1'($urandom_range(0, 1));
            d  = int'($urandom_range(0, NDIG));
            if ($urandom_range(0, 4) == 0) begin
                y = 16'($urandom);
            end else if (d < NDIG) begin
                y[d*DIGIT +: DIGIT] = y[d*DIGIT +: DIGIT] ^ 4'($urandom_range(1, 15));
                for (int j = 0; j < d; j++) begin
                    y[j*DIGIT +: DIGIT] = 4'($urandom);
                end
            end
            run(x, y, sm, model(x, y, sm));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits compared per cycle; WIDTH SHALL be a multiple of DIGIT, and NDIG = WIDTH/DIGIT.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a new compare; accepted only when busy=0.
REQ-006 Port signed_mode, input, 1 bit: 1 selects two's-complement compare, 0 selects unsigned; sampled with start.
REQ-007 Ports a and b, inputs, WIDTH bits each: operands, sampled on the accepting edge.
REQ-008 Port busy, output, 1 bit: high while digits are being scanned.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-010 Ports less, greater and equal, outputs, 1 bit each: result of the comparison a versus b; exactly one is high after the first done.
REQ-011 Port cycles, output, $clog2(NDIG)+1 bits: number of digits examined for the last result.

Function
REQ-012 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-013 IDLE or DONE with start=1 SHALL capture a, b and signed_mode, set the digit index to NDIG-1, and go to SCAN.
REQ-014 In signed mode the MSB of both captured operands SHALL be inverted at capture, so the scan is always an unsigned MSB-first compare.
REQ-015 Each SCAN cycle SHALL compare one DIGIT-bit slice at the index, MSB digit first.
REQ-016 If the slices differ in a SCAN cycle, the block SHALL register less or greater accordingly, clear equal, and go to DONE (early termination).
REQ-017 If the slices are equal and the index is 0, the block SHALL register equal=1, clear less and greater, and go to DONE.
REQ-018 If the slices are equal and the index is above 0, the block SHALL decrement the index and stay in SCAN.
REQ-019 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE unless start is accepted in that cycle.
REQ-020 Latency from the accepting edge to the done cycle SHALL be k cycles, where k (1..NDIG) is the number of digits examined; cycles SHALL equal k.
REQ-021 start while busy=1 SHALL be ignored and SHALL NOT disturb the captured operands.
REQ-022 less, greater, equal and cycles SHALL hold their values from a done cycle until the next done cycle, including across a new start.
REQ-023 Operand inputs may change freely after capture without affecting the result.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and busy=0, done=0, less=0, greater=0, equal=0, cycles=0, regardless of state; rst SHALL take priority over start.
REQ-025 A reset during SCAN SHALL abandon the compare with no done pulse.

Structure
REQ-026 The FSM state enum and the derived NDIG and index width SHALL live in the shared package comp_pkg.
REQ-027 The single-digit compare SHALL be a combinational sub-module digit_comp (DIGIT-bit inputs; lt, gt and eq outputs), instantiated once.

Verification (WIDTH=16, DIGIT=4)
REQ-028 Unsigned a=0x1234, b=0x1234 -> equal=1, done 4 cycles after accept, cycles=4.
REQ-029 a=0x8000, b=0x7FFF -> unsigned: greater=1, cycles=1, done 1 cycle after accept; signed: less=1, cycles=1.
REQ-030 Unsigned a=0x0012, b=0x0013 -> less=1, cycles=4; signed a=0xFFFF, b=0xFFFE -> greater=1, cycles=4.
REQ-031 Start again during SCAN with different operands -> ignored; first result unchanged. Then start in the DONE cycle -> accepted back-to-back, with no IDLE cycle in between.
REQ-032 rst asserted in the second SCAN cycle -> next cycle all outputs 0, state IDLE, no done pulse; a following start completes normally.
REQ-033 Random signed and unsigned operands, at least 1000 runs -> result matches a reference model, exactly one of less, greater and equal is high, and cycles equals the leading-differing-digit position count.
